// File: rtl/fe_bp_pkg.sv
// Shared fetch/branch-predictor definitions: mode encodings, counter states, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fe_bp_pkg;

    // Predictor operating modes.
    typedef enum logic [1:0] {
        PRED_STATIC  = 2'd0,   // always predict not-taken
        PRED_BIMODAL = 2'd1,   // PT indexed by PC only
        PRED_GSHARE  = 2'd2    // PT indexed by PC xor global history
    } pred_mode_e;

    // 2-bit saturating counter states; bit 1 is the predicted direction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Width of the FE latch handed to DE:
    // valid + inst + pc + pcplus + pred_taken + pred_target + pt_index + inst_count.
    function automatic int fe_latch_width(input int dbits, input int pt_index_bits);
        return 5 * dbits + pt_index_bits + 2;
    endfunction

    localparam int FE_LATCH_BITS = fe_latch_width(32, 8);

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        if (taken) r = (ctr == ST)  ? ST  : ctr + 2'd1;
        else       r = (ctr == SNT) ? SNT : ctr - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/fe_stage_gshare_if.sv
// Fetch-stage bus: DE stall, AGEX redirect/training, imem read port, FE latch to DE.
// Latency: n/a (wiring only).
// Backpressure: stall_i from DE freezes the FE latch; redirect_valid_i overrides it.
// master = environment side (drives stall/redirect/update/imem data),
// slave  = fetch stage (drives imem address and FE latch outputs).
interface fe_stage_gshare_if #(
    parameter int DBITS         = 32,
    parameter int PT_INDEX_BITS = 8
);
    logic                     stall_i;
    logic                     redirect_valid_i;
    logic [DBITS-1:0]         redirect_pc_i;
    logic                     upd_valid_i;
    logic [DBITS-1:0]         upd_pc_i;
    logic                     upd_taken_i;
    logic [DBITS-1:0]         upd_target_i;
    logic [PT_INDEX_BITS-1:0] upd_pt_index_i;
    logic [DBITS-1:0]         imem_addr_o;
    logic [DBITS-1:0]         imem_rdata_i;
    logic                     out_valid_o;
    logic [DBITS-1:0]         out_inst_o;
    logic [DBITS-1:0]         out_pc_o;
    logic [DBITS-1:0]         out_pcplus_o;
    logic                     out_pred_taken_o;
    logic [DBITS-1:0]         out_pred_target_o;
    logic [PT_INDEX_BITS-1:0] out_pt_index_o;
    logic [DBITS-1:0]         out_inst_count_o;

    modport master (
        output stall_i, redirect_valid_i, redirect_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pt_index_i,
               imem_rdata_i,
        input  imem_addr_o, out_valid_o, out_inst_o, out_pc_o, out_pcplus_o,
               out_pred_taken_o, out_pred_target_o, out_pt_index_o, out_inst_count_o
    );

    modport slave (
        input  stall_i, redirect_valid_i, redirect_pc_i,
               upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pt_index_i,
               imem_rdata_i,
        output imem_addr_o, out_valid_o, out_inst_o, out_pc_o, out_pcplus_o,
               out_pred_taken_o, out_pred_target_o, out_pt_index_o, out_inst_count_o
    );

endinterface

// File: rtl/fe_branch_predictor.sv
// Branch predictor: BTB + 2-bit pattern table (static/bimodal/gshare) with global history.
// Latency: lookup is combinational; training writes land at the next rising edge.
// Backpressure: none; training is accepted every cycle upd_valid is high.
// Ports: lookup_pc -> lookup_taken/lookup_target/lookup_pt_index; upd_* trains PT, BHR, BTB.
module fe_branch_predictor
    import fe_bp_pkg::*;
#(
    parameter int DBITS          = 32,
    parameter int PT_INDEX_BITS  = 8,
    parameter int BHR_BITS       = 8,
    parameter int BTB_INDEX_BITS = 4,
    parameter int PRED_MODE      = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DBITS-1:0]         lookup_pc,
    output logic                     lookup_taken,
    output logic [DBITS-1:0]         lookup_target,
    output logic [PT_INDEX_BITS-1:0] lookup_pt_index,
    input  logic                     upd_valid,
    input  logic [DBITS-1:0]         upd_pc,
    input  logic                     upd_taken,
    input  logic [DBITS-1:0]         upd_target,
    input  logic [PT_INDEX_BITS-1:0] upd_pt_index
);
    localparam int PT_N     = 1 << PT_INDEX_BITS;
    localparam int BTB_N    = 1 << BTB_INDEX_BITS;
    localparam int TAG_BITS = DBITS - BTB_INDEX_BITS - 2;

    logic [1:0]          pt         [PT_N];
    logic [BHR_BITS-1:0] bhr;
    logic                btb_vld    [BTB_N];
    logic [TAG_BITS-1:0] btb_tag    [BTB_N];
    logic [DBITS-1:0]    btb_target [BTB_N];

    logic [PT_INDEX_BITS-1:0]  pc_idx;
    logic [BTB_INDEX_BITS-1:0] lk_bi, up_bi;
    logic [TAG_BITS-1:0]       lk_tag, up_tag;
    logic                      btb_hit;

    // Instructions are word aligned, so the two low PC bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

    assign pc_idx = lookup_pc[PT_INDEX_BITS+1:2];
    assign lk_bi  = lookup_pc[BTB_INDEX_BITS+1:2];
    assign lk_tag = lookup_pc[DBITS-1:BTB_INDEX_BITS+2];
    assign up_bi  = upd_pc[BTB_INDEX_BITS+1:2];
    assign up_tag = upd_pc[DBITS-1:BTB_INDEX_BITS+2];

    // Static mode ignores the index, so it shares the bimodal form.
    assign lookup_pt_index = (PRED_MODE == int'(PRED_GSHARE))
                           ? (pc_idx ^ PT_INDEX_BITS'(bhr)) : pc_idx;

    assign btb_hit       = btb_vld[lk_bi] && (btb_tag[lk_bi] == lk_tag);
    assign lookup_taken  = (PRED_MODE != int'(PRED_STATIC)) && btb_hit && pt[lookup_pt_index][1];
    assign lookup_target = btb_target[lk_bi];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bhr <= '0;
            for (int i = 0; i < PT_N; i++)  pt[i]      <= WNT;
            for (int i = 0; i < BTB_N; i++) btb_vld[i] <= 1'b0;
        end else if (upd_valid) begin
            pt[upd_pt_index] <= ctr_next(pt[upd_pt_index], upd_taken);
            bhr              <= {bhr[BHR_BITS-2:0], upd_taken};
            if (upd_taken) btb_vld[up_bi] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only trusted behind btb_vld.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[up_bi]    <= up_tag;
            btb_target[up_bi] <= upd_target;
        end
    end

endmodule

// File: rtl/fe_stage_gshare.sv
// Fetch stage: PC register, imem address, next-PC prediction, registered FE latch to DE.
// Latency: instruction fetched in cycle N is presented to DE in cycle N+1; predictions are zero-bubble.
// Backpressure: stall_i holds PC/latch/count; redirect_valid_i beats stall and bubbles the latch.
// Ports: clk, reset_n (async, active-low), io (slave side of fe_stage_gshare_if).
module fe_stage_gshare
    import fe_bp_pkg::*;
#(
    parameter int               DBITS          = 32,
    parameter int               INSTSIZE       = 4,
    parameter logic [DBITS-1:0] STARTPC        = 'h200,
    parameter int               PT_INDEX_BITS  = 8,
    parameter int               BHR_BITS       = 8,
    parameter int               BTB_INDEX_BITS = 4,
    parameter int               PRED_MODE      = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fe_stage_gshare_if.slave   io
);
    typedef struct packed {
        logic                     valid;
        logic [DBITS-1:0]         inst;
        logic [DBITS-1:0]         pc;
        logic [DBITS-1:0]         pcplus;
        logic                     pred_taken;
        logic [DBITS-1:0]         pred_target;
        logic [PT_INDEX_BITS-1:0] pt_index;
        logic [DBITS-1:0]         inst_count;
    } fe_latch_t;

    localparam int LATCH_W = fe_latch_width(DBITS, PT_INDEX_BITS);

    logic [DBITS-1:0]         pc_q, inst_count_q, pc_plus, pred_next, btb_target;
    logic                     pred_taken;
    logic [PT_INDEX_BITS-1:0] pt_index;
    logic [LATCH_W-1:0]       latch_q;
    fe_latch_t                latch_d, latch;

    fe_branch_predictor #(
        .DBITS          (DBITS),
        .PT_INDEX_BITS  (PT_INDEX_BITS),
        .BHR_BITS       (BHR_BITS),
        .BTB_INDEX_BITS (BTB_INDEX_BITS),
        .PRED_MODE      (PRED_MODE)
    ) u_bp (
        .clk             (clk),
        .reset_n         (reset_n),
        .lookup_pc       (pc_q),
        .lookup_taken    (pred_taken),
        .lookup_target   (btb_target),
        .lookup_pt_index (pt_index),
        .upd_valid       (io.upd_valid_i),
        .upd_pc          (io.upd_pc_i),
        .upd_taken       (io.upd_taken_i),
        .upd_target      (io.upd_target_i),
        .upd_pt_index    (io.upd_pt_index_i)
    );

    assign pc_plus   = pc_q + DBITS'(INSTSIZE);
    assign pred_next = pred_taken ? btb_target : pc_plus;

    always_comb begin
        latch_d             = '0;
        latch_d.valid       = 1'b1;
        latch_d.inst        = io.imem_rdata_i;
        latch_d.pc          = pc_q;
        latch_d.pcplus      = pc_plus;
        latch_d.pred_taken  = pred_taken;
        latch_d.pred_target = pred_next;
        latch_d.pt_index    = pt_index;
        latch_d.inst_count  = inst_count_q;
    end

    // Redirect wins over stall: a stalled DE still must drop the wrong-path instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= STARTPC;
            latch_q      <= '0;
            inst_count_q <= DBITS'(1);
        end else if (io.redirect_valid_i) begin
            pc_q    <= io.redirect_pc_i;
            latch_q <= '0;
        end else if (!io.stall_i) begin
            pc_q         <= pred_next;
            latch_q      <= latch_d;
            inst_count_q <= inst_count_q + DBITS'(1);
        end
    end

    assign latch = fe_latch_t'(latch_q);

    assign io.imem_addr_o       = pc_q;
    assign io.out_valid_o       = latch.valid;
    assign io.out_inst_o        = latch.inst;
    assign io.out_pc_o          = latch.pc;
    assign io.out_pcplus_o      = latch.pcplus;
    assign io.out_pred_taken_o  = latch.pred_taken;
    assign io.out_pred_target_o = latch.pred_target;
    assign io.out_pt_index_o    = latch.pt_index;
    assign io.out_inst_count_o  = latch.inst_count;

endmodule
